// File: rtl/ula_serial_ctrl.sv
// ula_serial_ctrl: runs a WIDTH-bit operation on one external 4-bit 74181
// slice, one nibble per cycle, LSB nibble first, with the carry chained
// between nibbles through a register. Requests and responses use
// valid/ready handshakes; operands are latched at accept.
module ula_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_aeqb,
  output logic             busy,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  input  logic             alu_aeqb
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q;
  logic             aeqb_q;

  // The slice always sees nibble idx of the latched operands; outside RUN
  // idx is 0, so the ALU just idles on nibble 0.
  assign alu_a   = a_q[4*idx +: 4];
  assign alu_b   = b_q[4*idx +: 4];
  assign alu_s   = s_q;
  assign alu_m   = m_q;
  assign alu_cin = carry_q;

  // Response fields are the working registers themselves; they keep the
  // last result after DONE until the next accept clears them.
  assign rsp_f    = res_q;
  assign rsp_cout = carry_q;
  assign rsp_aeqb = aeqb_q;

  // Sequencer: accept, walk the nibbles, then hold the response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      carry_q   <= 1'b0;
      res_q     <= '0;
      aeqb_q    <= 1'b1;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= req_b;
            s_q       <= req_s;
            m_q       <= req_m;
            carry_q   <= req_cin;
            idx       <= '0;
            res_q     <= '0;
            aeqb_q    <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Carry is chained in logic mode too; the slice simply ignores it.
          res_q[4*idx +: 4] <= alu_f;
          carry_q           <= alu_cout;
          aeqb_q            <= aeqb_q & alu_aeqb;
          if (idx == IDX_LAST) begin
            idx       <= '0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          // No same-cycle accept: req_ready only returns with IDLE.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          idx       <= '0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Bench for ula_serial_ctrl (WIDTH=16) with a behavioural 74181 slice
// (active-high data, positive carry) attached to the alu_* ports.
module tb_ula_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_s;
  logic        req_m;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_f;
  logic        rsp_cout;
  logic        rsp_aeqb;
  logic        busy;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic        alu_cin;
  logic [3:0]  alu_f;
  logic        alu_cout;
  logic        alu_aeqb;

  int vectors;
  int miscompares;

  logic [15:0] got_f;
  logic        got_cout;
  logic        got_aeqb;
  logic        mon_aeqb;
  int          lat;
  logic [3:0]  cin_tr;
  logic [17:0] expv;

  ula_serial_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_aeqb(rsp_aeqb), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb)
  );

  // 74181 slice, active-high data: returns {a_eq_b, cout, f}.
  // Carry out comes from the arithmetic sum regardless of mode.
  function automatic logic [5:0] slice(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] s, input logic m,
                                       input logic cin);
    logic [3:0] x, y, lf, f;
    logic [4:0] sum;
    case (s)
      4'h0: begin x = a;      y = 4'h0;   lf = ~a;       end
      4'h1: begin x = a | b;  y = 4'h0;   lf = ~(a | b); end
      4'h2: begin x = a | ~b; y = 4'h0;   lf = ~a & b;   end
      4'h3: begin x = 4'hF;   y = 4'h0;   lf = 4'h0;     end
      4'h4: begin x = a;      y = a & ~b; lf = ~(a & b); end
      4'h5: begin x = a | b;  y = a & ~b; lf = ~b;       end
      4'h6: begin x = a;      y = ~b;     lf = a ^ b;    end
      4'h7: begin x = a & ~b; y = 4'hF;   lf = a & ~b;   end
      4'h8: begin x = a;      y = a & b;  lf = ~a | b;   end
      4'h9: begin x = a;      y = b;      lf = ~(a ^ b); end
      4'hA: begin x = a | ~b; y = a & b;  lf = b;        end
      4'hB: begin x = a & b;  y = 4'hF;   lf = a & b;    end
      4'hC: begin x = a;      y = a;      lf = 4'hF;     end
      4'hD: begin x = a | b;  y = a;      lf = a | ~b;   end
      4'hE: begin x = a | ~b; y = a;      lf = a | b;    end
      default: begin x = a;   y = 4'hF;   lf = a;        end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    f = m ? lf : sum[3:0];
    return {(f == 4'hF), sum[4], f};
  endfunction

  assign {alu_aeqb, alu_cout, alu_f} = slice(alu_a, alu_b, alu_s, alu_m, alu_cin);

  // Whole-word expectation: four slices rippled LSB first -> {aeqb, cout, f}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s, input logic m,
                                         input logic cin);
    logic [15:0] f;
    logic        c, eq;
    logic [5:0]  r;
    c = cin;
    eq = 1'b1;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      r = slice(a[4*i +: 4], b[4*i +: 4], s, m, c);
      f[4*i +: 4] = r[3:0];
      c = r[4];
      eq = eq & r[5];
    end
    return {eq, c, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction from IDLE; hold = cycles of rsp_ready=0 after rsp_valid.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                       input logic m, input logic cin, input int hold, input string tag);
    req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
    req_valid = 1'b1;
    chk({tag, "_req_ready_idle"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom);
    req_s = 4'($urandom); req_m = 1'($urandom); req_cin = 1'($urandom);
    chk({tag, "_busy_run"}, busy, 1);
    lat = 0;
    mon_aeqb = 1'b1;
    cin_tr = '0;
    while (!rsp_valid && lat < 20) begin
      if (lat < 4) cin_tr[lat] = alu_cin;
      mon_aeqb = mon_aeqb & alu_aeqb;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    got_f = rsp_f;
    got_cout = rsp_cout;
    got_aeqb = rsp_aeqb;
    chk({tag, "_aeqb_vs_monitor"}, got_aeqb, mon_aeqb);
    for (int h = 0; h < hold; h++) begin
      req_valid = ~req_valid;
      req_a = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_f"}, rsp_f, got_f);
      chk({tag, "_hold_ready"}, req_ready, 0);
    end
    // A request pending in the exit cycle must not be taken on that edge.
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk({tag, "_exit_valid"}, rsp_valid, 0);
    chk({tag, "_exit_busy"}, busy, 0);
    chk({tag, "_exit_f_kept"}, rsp_f, got_f);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  rs;
    logic        rm, rc;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a = 16'hDEAD; req_b = 16'hBEEF; req_s = 4'h9; req_m = 1'b0; req_cin = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_f", rsp_f, 16'h0000);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_aeqb", rsp_aeqb, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_alu_m", alu_m, 0);
    chk("rst_alu_cin", alu_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Add
    do_op(16'h1234, 16'h0FCD, 4'h9, 1'b0, 1'b0, 0, "add");
    chk("add_f", got_f, 16'h2201);
    chk("add_cout", got_cout, 0);

    // Carry ripple across all nibbles
    do_op(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, "carry");
    chk("carry_f", got_f, 16'h0000);
    chk("carry_cout", got_cout, 1);
    chk("carry_cin_trace", cin_tr, 4'b1110);

    // Logic mode
    do_op(16'hA5A5, 16'h0FF0, 4'h6, 1'b1, 1'b0, 0, "xor");
    chk("xor_f", got_f, 16'hAA55);
    do_op(16'h8001, 16'($urandom), 4'hF, 1'b1, 1'b1, 0, "pass_a");
    chk("pass_a_f", got_f, 16'h8001);

    // Backpressure, then the next request after the DONE exit
    do_op(16'h0102, 16'h0304, 4'h9, 1'b0, 1'b1, 3, "bp");
    chk("bp_f", got_f, 16'h0407);
    chk("bp_cout", got_cout, 0);
    do_op(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, "after_bp");
    chk("after_bp_f", got_f, 16'h0100);

    // Asynchronous reset during the second RUN cycle
    req_a = 16'h1111; req_b = 16'h2222; req_s = 4'h9; req_m = 1'b0; req_cin = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_f", rsp_f, 16'h0000);
    chk("midrst_rsp_aeqb", rsp_aeqb, 1);
    chk("midrst_alu_cin", alu_cin, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", rsp_valid, 0);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_no_valid", rsp_valid, 0);
    do_op(16'h0003, 16'h0004, 4'h9, 1'b0, 1'b0, 0, "postrst_add");
    chk("postrst_f", got_f, 16'h0007);

    // a_eq_b accumulation with A-B-1 (+cin)
    do_op(16'h3C3C, 16'h3C3C, 4'h6, 1'b0, 1'b0, 0, "aeqb0");
    chk("aeqb0_f", got_f, 16'hFFFF);
    chk("aeqb0_aeqb", got_aeqb, 1);
    do_op(16'h3C3C, 16'h3C3C, 4'h6, 1'b0, 1'b1, 0, "aeqb1");
    chk("aeqb1_f", got_f, 16'h0000);
    chk("aeqb1_aeqb", got_aeqb, 0);
    chk("aeqb1_cout", got_cout, 1);

    // Randomized operations against the rippled-slice model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 4'($urandom);
      rm = 1'($urandom);
      rc = 1'($urandom);
      if (i % 4 == 0) begin
        rb = ra; rs = 4'h6; rm = 1'b0;
      end
      expv = ref_op(ra, rb, rs, rm, rc);
      do_op(ra, rb, rs, rm, rc, int'($urandom_range(0, 2)), "rnd");
      chk("rnd_f", got_f, expv[15:0]);
      chk("rnd_cout", got_cout, expv[16]);
      chk("rnd_aeqb", got_aeqb, expv[17]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_serial_ctrl.md
Name: ula_serial_ctrl

Overview:
- Sequencer that runs WIDTH-bit arithmetic/logic operations on one 4-bit ula_74181 slice, one nibble per cycle, LSB nibble first.
- Carry is chained between nibbles in a register.
- Sits between a requester (valid/ready request and response) and a single external ula_74181 instance, whose ports it drives and samples.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4.
- NIB, WIDTH/4, number of nibbles (derived, localparam).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_s  in  4  function select, passed to ALU s
- req_m  in  1  mode (0 arithmetic, 1 logic), passed to ALU m
- req_cin  in  1  carry into nibble 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  requester takes result
- rsp_f  out  WIDTH  assembled result
- rsp_cout  out  1  carry out of the last nibble
- rsp_aeqb  out  1  AND of the per-nibble alu_aeqb samples
- busy  out  1  high in RUN or DONE
- alu_a  out  4  nibble of latched A to ALU
- alu_b  out  4  nibble of latched B to ALU
- alu_s  out  4  latched s
- alu_m  out  1  latched m
- alu_cin  out  1  carry into current nibble
- alu_f  in  4  ALU result (combinational from alu_* outputs)
- alu_cout  in  1  ALU carry out
- alu_aeqb  in  1  ALU a_eq_b

Behaviour:
- States: IDLE, RUN, DONE. 2-bit state register; nibble index idx of $clog2(NIB) bits, minimum 1 bit.
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, all operand/select/result registers 0, carry register 0, aeqb accumulator 1.
  - Outputs at reset: req_ready=1, rsp_valid=0, rsp_f=0, rsp_cout=0, rsp_aeqb=1, busy=0, alu_a/alu_b/alu_s=0, alu_m=0, alu_cin=0.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a/b/s/m/cin, carry reg<=req_cin, idx<=0, aeqb acc<=1, clear result reg, go to RUN.
- RUN:
  - req_ready=0.
  - alu_a=A[4*idx+:4], alu_b=B[4*idx+:4], alu_s/alu_m from latches, alu_cin=carry reg.
  - Each cycle: result[4*idx+:4]<=alu_f, carry reg<=alu_cout, aeqb acc<=acc&alu_aeqb, idx<=idx+1.
  - When idx==NIB-1, capture as above and go to DONE; idx wraps to 0.
  - RUN lasts exactly NIB cycles.
- Carry in logic mode: carry is chained identically when m=1; the ALU ignores it. rsp_cout is whatever the ALU reports.
- DONE:
  - rsp_valid=1; rsp_f=result reg, rsp_cout=carry reg, rsp_aeqb=acc.
  - Hold all response values stable while rsp_ready=0.
  - On rsp_ready: go to IDLE.
  - req_ready=0 in DONE. No same-cycle accept of a new request; the earliest new accept is the cycle after the DONE exit.
- Latency: handshake in cycle 0 → RUN in cycles 1..NIB → rsp_valid=1 from cycle NIB+1. For WIDTH=16 that is cycle 5. Minimum spacing between accepts is NIB+2 cycles.
- rsp_f/rsp_cout/rsp_aeqb are registers: they keep the last result after returning to IDLE until the next accept clears them. rsp_valid is 0 outside DONE.
- alu_* outputs in IDLE/DONE: drive nibble idx (0) of the latched operands; no requirement on ALU outputs then.
- req_* changes while busy: ignored, since operands are latched at accept.
- Reset mid-RUN or mid-DONE: immediate return to reset values; no partial response is ever presented.
- busy=1 in RUN and DONE.
- Width rule: rsp_f is exactly WIDTH bits. The final carry appears only on rsp_cout.

Test Plan (bench instantiates ula_74181 as the slice, WIDTH=16):
- Add, m=0 s=1001, A=16'h1234 B=16'h0FCD cin=0 → rsp_f=16'h2201, rsp_cout=0; rsp_valid rises exactly 5 cycles after the accept cycle.
- Carry chain, m=0 s=1001, A=16'hFFFF B=16'h0001 cin=0 → rsp_f=16'h0000, rsp_cout=1; alu_cin observed as 0,1,1,1 across the 4 RUN cycles.
- Logic XOR, m=1 s=0110, A=16'hA5A5 B=16'h0FF0 → rsp_f=16'hAA55. Separate case: m=1 s=1111, A=16'h8001 → rsp_f=16'h8001.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid while toggling req_valid and req_a → rsp_valid and rsp_f stay stable, req_ready=0, no accept. Next request is accepted only after the DONE exit.
- Reset mid-op: assert rst_n=0 asynchronously (off clock edge) during the 2nd RUN cycle → outputs take reset values immediately, rsp_valid never asserts. After release, A=16'h0003 B=16'h0004 add → rsp_f=16'h0007.
- aeqb: for any accepted op, rsp_aeqb equals the AND of the 4 alu_aeqb values monitored in the RUN cycles. Check with A=B=16'h3C3C in m=0 s=0110 for both cin values.
